// File: rtl/imem_arbiter_pkg.sv
// Shared state encoding, default bus widths and helpers for the instruction-memory arbiter.
package imem_arbiter_pkg;

  localparam int unsigned ImemPcDataWidth = 20;
  localparam int unsigned ImemInstrWidth  = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRdWait = 2'd1,
    StWr     = 2'd2
  } arb_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] val, input logic en);
    return (en && (val != 32'hFFFF_FFFF)) ? val + 32'd1 : val;
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, loader and SRAM bus bundle; the arbiter takes the slave view.
interface imem_arbiter_if
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned PC_DATA_WIDTH     = ImemPcDataWidth,
  parameter int unsigned INSTRUCTION_WIDTH = ImemInstrWidth
);

  logic                         fetch_req_in;
  logic [PC_DATA_WIDTH-1:0]     fetch_addr_in;
  logic [INSTRUCTION_WIDTH-1:0] fetch_data_out;
  logic                         fetch_valid_out;
  logic                         fetch_stall_out;

  logic                         load_req_in;
  logic [PC_DATA_WIDTH-1:0]     load_addr_in;
  logic [INSTRUCTION_WIDTH-1:0] load_data_in;
  logic                         load_ack_out;

  logic [PC_DATA_WIDTH-1:0]     mem_addr_out;
  logic [INSTRUCTION_WIDTH-1:0] mem_data_out;
  logic                         mem_rd_en_out;
  logic                         mem_wr_en_out;
  logic [INSTRUCTION_WIDTH-1:0] mem_data_in;

  modport master (
    output fetch_req_in, fetch_addr_in, load_req_in, load_addr_in, load_data_in, mem_data_in,
    input  fetch_data_out, fetch_valid_out, fetch_stall_out, load_ack_out,
    input  mem_addr_out, mem_data_out, mem_rd_en_out, mem_wr_en_out
  );

  modport slave (
    input  fetch_req_in, fetch_addr_in, load_req_in, load_addr_in, load_data_in, mem_data_in,
    output fetch_data_out, fetch_valid_out, fetch_stall_out, load_ack_out,
    output mem_addr_out, mem_data_out, mem_rd_en_out, mem_wr_en_out
  );

endinterface

// File: rtl/imem_arb_perf.sv
// Saturating stall-cycle and load-ack counters for the arbiter (built with IMEM_ARB_PERF_EN).
module imem_arb_perf
  import imem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        ack_i,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] load_cnt_o
);

  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] load_cnt_q, load_cnt_d;

  always_comb begin
    stall_cnt_d = sat_inc32(stall_cnt_q, stall_i);
    load_cnt_d  = sat_inc32(load_cnt_q, ack_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      load_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      load_cnt_q  <= load_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign load_cnt_o  = load_cnt_q;

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction SRAM arbiter: loader writes vs fetch reads with a starvation guard.
// Optional perf counters are built when IMEM_ARB_PERF_EN is defined.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned PC_DATA_WIDTH     = ImemPcDataWidth,
  parameter int unsigned INSTRUCTION_WIDTH = ImemInstrWidth,
  parameter int unsigned MEM_READ_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  imem_arbiter_if.slave bus
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt_out,
  output logic [31:0] perf_load_cnt_out
`endif
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
  localparam logic [2:0] LatCycles = 3'(MEM_READ_LATENCY);

  arb_state_e                   state_q, state_d;
  logic [2:0]                   wait_q, wait_d;
  logic [StarveW-1:0]           starve_q, starve_d;
  logic [PC_DATA_WIDTH-1:0]     addr_q, addr_d;
  logic [INSTRUCTION_WIDTH-1:0] data_q, data_d;
  logic                         valid_q, valid_d;

  logic                         rd_en, wr_en;
  logic [PC_DATA_WIDTH-1:0]     mem_addr;
  logic [INSTRUCTION_WIDTH-1:0] mem_wdata;
  logic                         stall;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    starve_d  = starve_q;
    addr_d    = addr_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = '0;

    unique case (state_q)
      StIdle: begin
        if (!bus.fetch_req_in) begin
          starve_d = '0;
        end
        // Loader wins unless fetch has already been passed over StarveMax times.
        if (bus.load_req_in && (starve_q < StarveMax)) begin
          state_d = StWr;
          if (bus.fetch_req_in) begin
            starve_d = starve_q + StarveW'(1);
          end
        end else if (bus.fetch_req_in) begin
          state_d  = StRdWait;
          rd_en    = 1'b1;
          mem_addr = bus.fetch_addr_in;
          addr_d   = bus.fetch_addr_in;
          wait_d   = 3'd1;
          starve_d = '0;
        end
      end

      StRdWait: begin
        if (wait_q == LatCycles) begin
          // A dropped request on the completion cycle is a flush: capture but stay silent.
          data_d  = bus.mem_data_in;
          valid_d = bus.fetch_req_in;
          wait_d  = '0;
          state_d = StIdle;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end

      StWr: begin
        wr_en     = 1'b1;
        mem_addr  = bus.load_addr_in;
        mem_wdata = bus.load_data_in;
        state_d   = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wait_q   <= '0;
      starve_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign stall               = bus.fetch_req_in & ~valid_q;
  assign bus.fetch_stall_out = stall;
  assign bus.fetch_data_out  = data_q;
  assign bus.fetch_valid_out = valid_q;
  assign bus.load_ack_out    = wr_en;
  assign bus.mem_addr_out    = mem_addr;
  assign bus.mem_data_out    = mem_wdata;
  assign bus.mem_rd_en_out   = rd_en;
  assign bus.mem_wr_en_out   = wr_en;

`ifdef IMEM_ARB_PERF_EN
  imem_arb_perf u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_i     (stall),
    .ack_i       (wr_en),
    .stall_cnt_o (perf_stall_cnt_out),
    .load_cnt_o  (perf_load_cnt_out)
  );
`endif

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port instruction SRAM between two requesters: the fetch stage (reads) and the program loader (writes, used for boot and debug download).
- Sits between the fetch stage and the instruction SRAM.
- Sequences SRAM access with a fixed read latency and returns fetched words with a valid pulse.
- Exports a stall so the PC holds while an access is pending or the loader owns the memory.

Parameters:
PC_DATA_WIDTH, 20, address width of fetch, loader and SRAM address buses
INSTRUCTION_WIDTH, 32, SRAM data width
MEM_READ_LATENCY, 1, cycles from rd_en issue to valid mem_data_in; legal range 1..4
STARVE_LIMIT, 8, max consecutive loader grants while fetch is pending; must be >=1

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
fetch_req_in  input  1  fetch wants a word at fetch_addr_in
fetch_addr_in  input  PC_DATA_WIDTH  fetch byte address (current pc)
fetch_data_out  output  INSTRUCTION_WIDTH  fetched word; valid only when fetch_valid_out=1
fetch_valid_out  output  1  one-cycle pulse, fetch_data_out valid
fetch_stall_out  output  1  hold pc this cycle
load_req_in  input  1  loader write request; held until ack
load_addr_in  input  PC_DATA_WIDTH  loader write address
load_data_in  input  INSTRUCTION_WIDTH  loader write data
load_ack_out  output  1  one-cycle pulse, write performed
mem_addr_out  output  PC_DATA_WIDTH  SRAM address
mem_data_out  output  INSTRUCTION_WIDTH  SRAM write data
mem_rd_en_out  output  1  SRAM read strobe
mem_wr_en_out  output  1  SRAM write strobe
mem_data_in  input  INSTRUCTION_WIDTH  SRAM read data

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-low on rst_n. Every register is reset.
- Reset values: all registered outputs 0; state IDLE; wait and starve counters 0. An in-flight read is discarded with no valid pulse.
- States:
  - IDLE: arbitrate.
  - RD_WAIT: count MEM_READ_LATENCY cycles.
  - WR: one write cycle.
- IDLE arbitration:
  - Loader has priority: if load_req_in=1 and starve_cnt<STARVE_LIMIT, go to WR.
  - Otherwise, if fetch_req_in=1, issue a read: mem_rd_en_out=1 for one cycle, mem_addr_out=fetch_addr_in registered at issue, go to RD_WAIT.
  - Neither request: stay in IDLE with strobes 0.
- RD_WAIT:
  - After MEM_READ_LATENCY cycles, capture mem_data_in into fetch_data_out and pulse fetch_valid_out, then return to IDLE.
  - If fetch_req_in=0 on the completion cycle (flush), data is captured but fetch_valid_out stays 0.
  - Address is held from issue; fetch_addr_in changes during RD_WAIT are ignored.
- WR:
  - mem_wr_en_out=1, mem_addr_out=load_addr_in, mem_data_out=load_data_in, and load_ack_out=1, all in the same cycle; then return to IDLE.
  - The loader may keep load_req_in high for back-to-back writes, one write every 2 cycles.
- Read throughput: one word every MEM_READ_LATENCY+1 cycles.
- Starvation guard:
  - starve_cnt increments on each WR grant taken while fetch_req_in=1.
  - It saturates at STARVE_LIMIT, which forces the next IDLE grant to fetch.
  - It clears on every fetch grant, or whenever fetch_req_in=0 in IDLE.
- Simultaneous requests in IDLE: loader wins unless starve_cnt==STARVE_LIMIT.
- fetch_stall_out = fetch_req_in & ~fetch_valid_out (combinational).
- Strobe exclusivity: mem_rd_en_out and mem_wr_en_out are never high in the same cycle.

Optional Feature:
- Macro: IMEM_ARB_PERF_EN.
- When defined:
  - Adds output port perf_stall_cnt_out (32 bits), which counts cycles with fetch_stall_out=1.
  - Adds output port perf_load_cnt_out (32 bits), which counts load acks.
  - Both counters saturate at all-ones and reset to 0.
- When undefined: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=2'd0, RD_WAIT=2'd1, WR=2'd2.
  - Default widths PC_DATA_WIDTH and INSTRUCTION_WIDTH, shared with the fetch stage.
- Sub-module imem_arb_perf: the saturating counter pair, instantiated only under IMEM_ARB_PERF_EN. The core FSM stays in one module.

Test Plan:
- Reset held then released, no requests -> all outputs 0; stays IDLE; no strobes.
- fetch_req_in=1, addr 0x00004, MEM_READ_LATENCY=1, SRAM returns 0xDEADBEEF -> rd_en at cycle 0, mem_addr_out=0x00004; fetch_valid_out pulses at cycle 2 with 0xDEADBEEF; stall high in cycles 0-1.
- load_req_in=1, addr 0x00010, data 0x12345678, fetch idle -> one-cycle wr_en with those values and load_ack_out in the same cycle.
- Loader and fetch both held high, STARVE_LIMIT=8 -> exactly 8 write acks, then one fetch valid, then the loader resumes.
- fetch_req_in dropped on the completion cycle of a read -> no fetch_valid_out pulse; next read issues normally.
- rst_n asserted during RD_WAIT -> outputs 0 immediately; no valid pulse after release. With IMEM_ARB_PERF_EN defined, stall counter equals the bench's count of stall cycles.
